// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg (flush sequencer slice)
//
// Shared types for the flush sequencer:
//   FLUSH_OP_W         width of one requester's flush op field
//   flush_op_t         {tlb, icache, dcache}; dcache is bit 0
//   flush_seq_state_e  sequencer states
//   step_after_drain() next state once the dcache part of a flush is over
//   first_step()       first action state for a freshly granted op
// ---------------------------------------------------------------------------
package ariane_pkg;

    localparam int FLUSH_OP_W = 3;

    typedef struct packed {
        logic tlb;
        logic icache;
        logic dcache;
    } flush_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DCACHE = 3'd1,
        DRAIN  = 3'd2,
        ICACHE = 3'd3,
        TLB    = 3'd4,
        DONE   = 3'd5
    } flush_seq_state_e;

    // The steps after the dcache/drain phase, in fixed order.
    function automatic flush_seq_state_e step_after_drain(input flush_op_t op);
        flush_seq_state_e s;
        if (op.icache) begin
            s = ICACHE;
        end else if (op.tlb) begin
            s = TLB;
        end else begin
            s = DONE;
        end
        return s;
    endfunction

    // An op with no bits set goes straight to DONE.
    function automatic flush_seq_state_e first_step(input flush_op_t op);
        flush_seq_state_e s;
        if (op.dcache) begin
            s = DCACHE;
        end else begin
            s = step_after_drain(op);
        end
        return s;
    endfunction

endpackage

// File: rtl/flush_seq_rr_arb.sv
// ---------------------------------------------------------------------------
// flush_seq_rr_arb
//
// Purely combinational round-robin arbiter. The search starts at ptr and
// wraps modulo NrReq; the first requesting slot found wins.
//
// Ports:
//   req        in   NrReq   request vector
//   ptr        in   IdxW    priority pointer (slot searched first), < NrReq
//   gnt        out  NrReq   one-hot grant (all zero when nothing requests)
//   gnt_idx    out  IdxW    index of the granted slot
//   gnt_valid  out  1       some slot was granted
// ---------------------------------------------------------------------------
module flush_seq_rr_arb #(
    parameter int NrReq = 3,
    parameter int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] req,
    input  logic [IdxW-1:0]  ptr,
    output logic [NrReq-1:0] gnt,
    output logic [IdxW-1:0]  gnt_idx,
    output logic             gnt_valid
);

    localparam logic [IdxW:0] NrReqW = (IdxW + 1)'(NrReq);

    logic [IdxW:0] cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        // Walk from the farthest offset back toward the pointer so that the
        // nearest requesting slot is the last one written, i.e. the winner.
        for (int k = NrReq - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IdxW + 1)'(k);
            if (cand >= NrReqW) begin
                cand = cand - NrReqW;
            end
            if (req[cand[IdxW-1:0]]) begin
                gnt_idx   = cand[IdxW-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NrReq; gi++) begin : g_gnt
            assign gnt[gi] = gnt_valid && (gnt_idx == IdxW'(gi));
        end
    endgenerate

endmodule

// File: rtl/flush_sequencer.sv
// ---------------------------------------------------------------------------
// flush_sequencer
//
// Arbitrates flush requests from several requesters and runs the granted
// one through: dcache flush (wait ack) -> drain of external transactions ->
// icache flush -> TLB flush -> done pulse. Steps not enabled in the op are
// skipped. Only one sequence is in flight at a time; busy_o halts commit.
//
// Optional feature: define FLUSH_SEQ_TIMEOUT_EN to add a dcache-ack watchdog.
// When it fires, timeout_o is set (sticky until reset) and the sequence moves
// on to DRAIN as if the ack had arrived. Without the macro DCACHE waits for
// the ack indefinitely and timeout_o is constant 0.
//
// Parameters: NrReq (1..8), DrainCycles (1..256), TimeoutCycles (2..65536)
//
// Ports:
//   clk_i               in   core clock
//   rst_i               in   asynchronous active-high reset
//   req_valid_i         in   NrReq      flush request per requester
//   req_op_i            in   3*NrReq    per-requester op, [3i+2:3i]
//   req_ready_o         out  NrReq      one-hot accept (combinational, IDLE)
//   done_o              out  NrReq      completion pulse to granted requester
//   flush_dcache_o      out  dcache flush request (level, in DCACHE)
//   flush_dcache_ack_i  in   dcache flush done
//   cache_busy_i        in   outstanding external transactions
//   flush_icache_o      out  icache flush pulse
//   flush_tlb_o         out  TLB flush pulse
//   busy_o              out  sequence in flight
//   timeout_o           out  sticky watchdog flag
// ---------------------------------------------------------------------------
module flush_sequencer
    import ariane_pkg::*;
#(
    parameter int NrReq         = 3,
    parameter int DrainCycles   = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NrReq-1:0]            req_valid_i,
    input  logic [FLUSH_OP_W*NrReq-1:0] req_op_i,
    output logic [NrReq-1:0]            req_ready_o,
    output logic [NrReq-1:0]            done_o,
    output logic                        flush_dcache_o,
    input  logic                        flush_dcache_ack_i,
    input  logic                        cache_busy_i,
    output logic                        flush_icache_o,
    output logic                        flush_tlb_o,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int IdxW   = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int DrainW = $clog2(DrainCycles + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NrReq - 1);

    flush_seq_state_e  state_reg, state_next;
    logic [IdxW-1:0]   gnt_idx_reg;
    flush_op_t         op_reg;
    logic [IdxW-1:0]   ptr_reg, ptr_next;
    logic [DrainW-1:0] drain_cnt_reg;

    flush_op_t         req_ops [NrReq];
    logic [NrReq-1:0]  arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_valid;
    logic              drain_done;
    logic              dcache_exit;

    genvar gi;
    generate
        for (gi = 0; gi < NrReq; gi++) begin : g_unpack
            assign req_ops[gi] = flush_op_t'(req_op_i[FLUSH_OP_W*gi +: FLUSH_OP_W]);
        end
    endgenerate

    flush_seq_rr_arb #(
        .NrReq (NrReq),
        .IdxW  (IdxW)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (ptr_reg),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Drain ends on the DrainCycles-th consecutive idle cycle; a busy cycle
    // restarts the count.
    assign drain_done = (state_reg == DRAIN) && !cache_busy_i && (drain_cnt_reg == DrainLast);

    // Pointer moves to the slot after the one just served.
    assign ptr_next = (gnt_idx_reg == LastIdx) ? '0 : gnt_idx_reg + IdxW'(1);

`ifdef FLUSH_SEQ_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0] wd_cnt_reg;
    logic           timeout_reg;
    logic           wd_expired;

    // An ack in the same cycle wins; the flag is only raised when the ack
    // genuinely never came.
    assign wd_expired  = (state_reg == DCACHE) && !flush_dcache_ack_i && (wd_cnt_reg == WdLast);
    assign dcache_exit = flush_dcache_ack_i || wd_expired;
    assign timeout_o   = timeout_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg != DCACHE) begin
                wd_cnt_reg <= '0;
            end else if (wd_cnt_reg != WdLast) begin
                wd_cnt_reg <= wd_cnt_reg + WdW'(1);
            end
            if (wd_expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end
`else
    assign dcache_exit = flush_dcache_ack_i;
    // Always 0: TimeoutCycles is at least 2; it has no other role here.
    assign timeout_o   = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next = first_step(req_ops[arb_idx]);
                end
            end
            DCACHE: begin
                if (dcache_exit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = step_after_drain(op_reg);
                end
            end
            ICACHE:  state_next = op_reg.tlb ? TLB : DONE;
            TLB:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            gnt_idx_reg   <= '0;
            op_reg        <= '0;
            ptr_reg       <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && arb_valid) begin
                gnt_idx_reg <= arb_idx;
                op_reg      <= req_ops[arb_idx];
            end
            if (state_reg == DONE) begin
                ptr_reg <= ptr_next;
            end
            if ((state_reg != DRAIN) || cache_busy_i) begin
                drain_cnt_reg <= '0;
            end else if (drain_cnt_reg != DrainLast) begin
                drain_cnt_reg <= drain_cnt_reg + DrainW'(1);
            end
        end
    end

    // Accept is the only Mealy output; it is held low while reset is applied.
    assign req_ready_o    = ((state_reg == IDLE) && !rst_i) ? arb_gnt : '0;
    assign flush_dcache_o = (state_reg == DCACHE);
    assign flush_icache_o = (state_reg == ICACHE);
    assign flush_tlb_o    = (state_reg == TLB);
    assign busy_o         = (state_reg != IDLE);

    generate
        for (gi = 0; gi < NrReq; gi++) begin : g_done
            assign done_o[gi] = (state_reg == DONE) && (gnt_idx_reg == IdxW'(gi));
        end
    endgenerate

endmodule
